// File: rtl/breath_sequencer.sv
// ----------------------------------------------------------------------------
// breath_sequencer
//
// Drives a "breathing" LED. The duty value follows a repeating trapezoid:
// ramp up, hold at full, ramp down, hold at off. A PWM comparator turns the
// duty value into the LED drive. The ramp rate is set by a prescaler that
// counts whole PWM periods. The hold length is set by a count of duty steps.
// Both values are loaded at runtime through a shadow register pair.
//
// Optional build macro:
//   BREATH_GAMMA_EN - when defined, the duty value is squared (duty*duty >>
//                     PWM_BITS, with full scale pinned to full scale) before
//                     the PWM compare. This adds one register stage between
//                     duty and pwm. When it is undefined, the compare uses the
//                     linear duty value directly and no multiplier exists.
//
// Parameters:
//   PWM_BITS - width of duty and of the PWM counter. The PWM period is
//              2^PWM_BITS-1 clocks.
//   DIV_W    - width of the ramp step divider.
//   HOLD_W   - width of the hold-step counter.
//
// Ports:
//   clk        in   system clock
//   rstn       in   asynchronous active-low reset
//   en         in   level. 1 = keep breathing. 0 = finish the current cycle,
//                   then idle.
//   cfg_load   in   one-clock pulse that captures ramp_div and hold_steps
//   ramp_div   in   PWM periods per duty step, minus 1
//   hold_steps in   duty-step ticks spent in each hold state (0 = no hold)
//   pwm        out  LED drive (registered)
//   duty       out  current linear duty value
//   phase      out  IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4
//   busy       out  high whenever phase is not IDLE
//   cycle_done out  one-clock pulse as each full breathing cycle ends
// ----------------------------------------------------------------------------
module breath_sequencer #(
  parameter int PWM_BITS = 8,
  parameter int DIV_W    = 16,
  parameter int HOLD_W   = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic                cfg_load,
  input  logic [DIV_W-1:0]    ramp_div,
  input  logic [HOLD_W-1:0]   hold_steps,
  output logic                pwm,
  output logic [PWM_BITS-1:0] duty,
  output logic [2:0]          phase,
  output logic                busy,
  output logic                cycle_done
);

  // Full-scale duty (all ones) and the last PWM counter value of a period.
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
  localparam logic [PWM_BITS-1:0] CNT_LAST = DUTY_MAX - PWM_BITS'(1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_UP      = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_DOWN    = 3'd3,
    ST_HOLD_LO = 3'd4
  } state_t;

  // Saturating duty arithmetic: never wraps past full scale or below zero.
  function automatic logic [PWM_BITS-1:0] sat_inc(input logic [PWM_BITS-1:0] d);
    return (d == DUTY_MAX) ? d : d + PWM_BITS'(1);
  endfunction

  function automatic logic [PWM_BITS-1:0] sat_dec(input logic [PWM_BITS-1:0] d);
    return (d == '0) ? d : d - PWM_BITS'(1);
  endfunction

`ifdef BREATH_GAMMA_EN
  // Square-law brightness curve. Full scale is pinned so that the top of the
  // ramp still gives a constantly-on LED.
  function automatic logic [PWM_BITS-1:0] gamma_map(input logic [PWM_BITS-1:0] d);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
    return (d == DUTY_MAX) ? DUTY_MAX : PWM_BITS'(sq >> PWM_BITS);
  endfunction
`endif

  state_t              state;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_eff;
  logic [DIV_W-1:0]    div_cnt;
  logic [DIV_W-1:0]    ramp_div_s;
  logic [DIV_W-1:0]    ramp_div_q;
  logic [HOLD_W-1:0]   hold_s;
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   hold_cnt;

  logic                running;
  logic                period_end;
  logic                step;
  logic                hold_skip;
  logic                hold_last;
  logic [PWM_BITS-1:0] duty_inc;
  logic [PWM_BITS-1:0] duty_dec;
  logic                down_bot;
  logic                cycle_end;
  logic                apply_cfg;

  assign running    = (state != ST_IDLE);
  assign busy       = running;
  assign phase      = state;

  assign period_end = running && (pwm_cnt == CNT_LAST);
  assign step       = period_end && (div_cnt == ramp_div_q);

  assign duty_inc   = sat_inc(duty);
  assign duty_dec   = sat_dec(duty);
  assign hold_skip  = (hold_q == '0);
  assign hold_last  = (hold_cnt == hold_q - HOLD_W'(1));
  assign down_bot   = (state == ST_DOWN) && step && (duty_dec == '0);

  // A cycle ends at the HOLD_LO exit. When the hold is skipped, it ends at the
  // bottom of the down ramp instead.
  assign cycle_end  = (down_bot && hold_skip) ||
                      ((state == ST_HOLD_LO) && step && hold_last);

  // Active config only changes between cycles, so a ramp never changes rate
  // partway through.
  assign apply_cfg  = (state == ST_IDLE) || cycle_end;

  // Shadow and active configuration. A load on the same clock as an apply
  // goes straight through to the active registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ramp_div_s <= '0;
      hold_s     <= '0;
      ramp_div_q <= '0;
      hold_q     <= '0;
    end else begin
      if (cfg_load) begin
        ramp_div_s <= ramp_div;
        hold_s     <= hold_steps;
      end
      if (apply_cfg) begin
        ramp_div_q <= cfg_load ? ramp_div   : ramp_div_s;
        hold_q     <= cfg_load ? hold_steps : hold_s;
      end
    end
  end

  // PWM period counter and step prescaler. Both are parked at zero while idle,
  // so the first period of a new run starts cleanly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwm_cnt <= '0;
      div_cnt <= '0;
    end else if (!running) begin
      pwm_cnt <= '0;
      div_cnt <= '0;
    end else begin
      pwm_cnt <= period_end ? '0 : pwm_cnt + PWM_BITS'(1);
      if (period_end) begin
        div_cnt <= (div_cnt == ramp_div_q) ? '0 : div_cnt + DIV_W'(1);
      end
    end
  end

  // Trapezoid sequencer. en is only sampled when leaving IDLE and when a cycle
  // ends, so dropping it mid-cycle always lets the LED finish dark.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      duty       <= '0;
      hold_cnt   <= '0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          duty     <= '0;
          hold_cnt <= '0;
          if (en) begin
            state <= ST_UP;
          end
        end

        ST_UP: begin
          if (step) begin
            duty <= duty_inc;
            if (duty_inc == DUTY_MAX) begin
              hold_cnt <= '0;
              state    <= hold_skip ? ST_DOWN : ST_HOLD_HI;
            end
          end
        end

        ST_HOLD_HI: begin
          if (step) begin
            if (hold_last) begin
              hold_cnt <= '0;
              state    <= ST_DOWN;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end

        ST_DOWN: begin
          if (step) begin
            duty <= duty_dec;
            if (duty_dec == '0) begin
              hold_cnt <= '0;
              if (hold_skip) begin
                cycle_done <= 1'b1;
                state      <= en ? ST_UP : ST_IDLE;
              end else begin
                state <= ST_HOLD_LO;
              end
            end
          end
        end

        ST_HOLD_LO: begin
          if (step) begin
            if (hold_last) begin
              hold_cnt   <= '0;
              cycle_done <= 1'b1;
              state      <= en ? ST_UP : ST_IDLE;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end

        default: begin
          state    <= ST_IDLE;
          duty     <= '0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

`ifdef BREATH_GAMMA_EN
  // ---- stage p1: gamma-corrected duty ----
  logic [PWM_BITS-1:0] duty_eff_p1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      duty_eff_p1 <= '0;
    end else begin
      duty_eff_p1 <= gamma_map(duty);
    end
  end

  assign duty_eff = duty_eff_p1;
`else
  assign duty_eff = duty;
`endif

  // ---- output stage: registered PWM compare ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pwm <= 1'b0;
    end else begin
      pwm <= (pwm_cnt < duty_eff);
    end
  end

endmodule

// File: tb/tb_breath_sequencer.sv
module tb_breath_sequencer;

  localparam int PB  = 4;
  localparam int DW  = 16;
  localparam int HW  = 8;
  localparam int MAX = (1 << PB) - 1;

  logic          clk = 1'b0;
  logic          rstn;
  logic          en;
  logic          cfg_load;
  logic [DW-1:0] ramp_div;
  logic [HW-1:0] hold_steps;
  logic          pwm;
  logic [PB-1:0] duty;
  logic [2:0]    phase;
  logic          busy;
  logic          cycle_done;

  breath_sequencer #(.PWM_BITS(PB), .DIV_W(DW), .HOLD_W(HW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .cfg_load(cfg_load),
    .ramp_div(ramp_div), .hold_steps(hold_steps),
    .pwm(pwm), .duty(duty), .phase(phase), .busy(busy),
    .cycle_done(cycle_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rd;
    int hold;
  } cyc_t;

  cyc_t exp_q[$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference trapezoid, in whole duty steps from the first UP clock.
  function automatic int step_clks(input int rd);
    return (rd + 1) * MAX;
  endfunction

  function automatic int duty_model(input int o, input int rd, input int h);
    int k;
    k = o / step_clks(rd);
    if (k < MAX)              return k;
    else if (k < MAX + h)     return MAX;
    else if (k < 2 * MAX + h) return 2 * MAX + h - k;
    else                      return 0;
  endfunction

  function automatic int phase_model(input int o, input int rd, input int h);
    int k;
    k = o / step_clks(rd);
    if (k < MAX)              return 1;
    else if (k < MAX + h)     return 2;
    else if (k < 2 * MAX + h) return 3;
    else                      return 4;
  endfunction

  function automatic int pwm_model(input int o, input int rd, input int h);
    if (o == 0) return 0;
    return (((o - 1) % MAX) < duty_model(o - 1, rd, h)) ? 1 : 0;
  endfunction

  function automatic int cycle_len(input int rd, input int h);
    return step_clks(rd) * (2 * MAX + 2 * h);
  endfunction

  // Monitor: tracks each cycle against the front of the queue, pops on
  // cycle_done.
  int busy_cnt = 0;
  int energy   = 0;
  int derr     = 0;
  int pherr    = 0;
  int perr     = 0;
  int stray    = 0;

  always @(negedge clk) begin
    cyc_t c;
    if (!rstn) begin
      busy_cnt = 0; energy = 0; derr = 0; pherr = 0; perr = 0;
    end else begin
      if (cycle_done) begin
        check("done_has_expect", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          c = exp_q.pop_front();
          check("cycle_len", busy_cnt, cycle_len(c.rd, c.hold));
          check("cycle_energy", energy, (c.rd + 1) * MAX * (MAX + c.hold));
          check("duty_track_errs", derr, 0);
          check("phase_track_errs", pherr, 0);
          check("pwm_track_errs", perr, 0);
        end
        busy_cnt = 0; energy = 0; derr = 0; pherr = 0; perr = 0;
      end
      if (busy) begin
        if (exp_q.size() == 0) begin
          stray++;
        end else begin
          c = exp_q[0];
          if (int'(duty)  != duty_model(busy_cnt, c.rd, c.hold))  derr++;
          if (int'(phase) != phase_model(busy_cnt, c.rd, c.hold)) pherr++;
          if (int'(pwm)   != pwm_model(busy_cnt, c.rd, c.hold))   perr++;
          energy += int'(pwm);
          busy_cnt++;
        end
      end
    end
  end

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (cycle_done) seen = 1'b1;
    end
    check("done_seen", int'(seen), 1);
  endtask

  task automatic wait_phase(input int p, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (int'(phase) == p) seen = 1'b1;
    end
    check("phase_reached", int'(seen), 1);
  endtask

  task automatic check_idle();
    check("idle_phase", int'(phase), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_pwm", int'(pwm), 0);
    check("idle_duty", int'(duty), 0);
    check("idle_done_low", int'(cycle_done), 0);
  endtask

  // Called at offset 0 of the final cycle: drop en somewhere inside its UP
  // ramp, then expect one last cycle_done and a dark idle.
  task automatic drop_and_finish(input int rd, input int h);
    repeat ($urandom_range(1, step_clks(rd) * MAX - 1)) @(negedge clk);
    en = 1'b0;
    wait_done(cycle_len(rd, h) + 50);
    @(negedge clk);
    check_idle();
  endtask

  task automatic run(input int n, input int rd0, input int h0,
                     input bit midload, input int rd1, input int h1);
    cyc_t c;
    @(negedge clk);
    ramp_div   = DW'(rd0);
    hold_steps = HW'(h0);
    cfg_load   = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    for (int i = 0; i < n; i++) begin
      c.rd   = (i > 0 && midload) ? rd1 : rd0;
      c.hold = (i > 0 && midload) ? h1  : h0;
      exp_q.push_back(c);
    end
    en = 1'b1;
    @(negedge clk);
    check("up_entry_phase", int'(phase), 1);
    check("up_entry_duty", int'(duty), 0);
    if (midload) begin
      wait_phase(3, cycle_len(rd0, h0));
      ramp_div   = DW'(rd1);
      hold_steps = HW'(h1);
      cfg_load   = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
    end
    for (int i = 1; i < n; i++) begin
      wait_done(cycle_len(rd0, h0) + 50);
    end
    if (n > 1 && midload) drop_and_finish(rd1, h1);
    else                  drop_and_finish(rd0, h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, rd, h, rd1, h1;
    bit ml;
    rstn = 1'b0; en = 1'b0; cfg_load = 1'b0; ramp_div = '0; hold_steps = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pwm", int'(pwm), 0);
    check("rst_duty", int'(duty), 0);
    check("rst_phase", int'(phase), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(cycle_done), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Basic trapezoid with holds, two cycles back to back.
    run(2, 0, 2, 1'b0, 0, 0);
    // No hold states.
    run(1, 0, 0, 1'b0, 0, 0);
    // Config change during DOWN takes effect on the next cycle only.
    run(2, 0, 1, 1'b1, 3, 2);

    for (int r = 0; r < 3; r++) begin
      n   = $urandom_range(1, 2);
      rd  = $urandom_range(0, 2);
      h   = $urandom_range(0, 3);
      ml  = (n == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      rd1 = $urandom_range(0, 2);
      h1  = $urandom_range(0, 3);
      run(n, rd, h, ml, rd1, h1);
    end

    // Asynchronous reset during HOLD_HI.
    @(negedge clk);
    ramp_div = DW'(0); hold_steps = HW'(2); cfg_load = 1'b1;
    @(negedge clk);
    cfg_load = 1'b0;
    begin
      cyc_t c;
      c.rd = 0; c.hold = 2;
      exp_q.push_back(c);
    end
    en = 1'b1;
    wait_phase(2, cycle_len(0, 2));
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("arst_pwm", int'(pwm), 0);
    check("arst_duty", int'(duty), 0);
    check("arst_phase", int'(phase), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_done", int'(cycle_done), 0);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    // Reset also cleared the config, so the restart runs with no ramp divider
    // and no holds.
    begin
      cyc_t c;
      c.rd = 0; c.hold = 0;
      exp_q.push_back(c);
    end
    rstn = 1'b1;
    @(negedge clk);
    check("restart_phase", int'(phase), 1);
    check("restart_duty", int'(duty), 0);
    drop_and_finish(0, 0);

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("stray_busy", stray, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
